// File: rtl/dms_pfd_lock_monitor.sv
// Multi-channel PFD/charge-pump health and lock monitor: per-channel lock FSM,
// saturating slip counters and sticky d_low / cp_range / overlap error flags.
module dms_pfd_lock_monitor #(
  parameter int unsigned NCH         = 2,
  parameter int unsigned CODE_W      = 8,
  parameter int unsigned CP_MIN      = 0,
  parameter int unsigned CP_MAX      = 230,
  parameter int unsigned LOCK_CYCLES = 16,
  parameter int unsigned SLIP_MAX    = 4,
  parameter int unsigned OVL_MAX     = 2,
  parameter int unsigned SLIP_W      = 4
) (
  input  logic                     refclk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     clr,
  input  logic [NCH-1:0]           d,
  input  logic [NCH-1:0]           up,
  input  logic [NCH-1:0]           down,
  input  logic [NCH*CODE_W-1:0]    cp_code,
  output logic [NCH-1:0]           lock,
  output logic [NCH*3-1:0]         err,
  output logic                     err_any,
  output logic [NCH*SLIP_W-1:0]    slip_cnt
);

  localparam int unsigned QW = $clog2(LOCK_CYCLES + 1);
  localparam int unsigned AW = $clog2(SLIP_MAX + 1);
  localparam int unsigned OW = $clog2(OVL_MAX + 2);
  localparam logic [CODE_W:0]   MIN_V  = (CODE_W+1)'(CP_MIN);
  localparam logic [CODE_W:0]   MAX_V  = (CODE_W+1)'(CP_MAX);
  localparam logic [SLIP_W-1:0] S_SAT  = {SLIP_W{1'b1}};
  localparam logic [OW-1:0]     O_SAT  = OW'(OVL_MAX + 1);

  typedef enum logic [1:0] {IDLE, ACQ, LOCKED} state_t;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_t              st, st_n;
    logic [QW-1:0]       q, q_n;
    logic [AW-1:0]       a, a_n;
    logic [OW-1:0]       o, o_n;
    logic [2:0]          e, e_n;
    logic [SLIP_W-1:0]   s, s_n, s_base;
    logic                lk, lk_n;
    logic [CODE_W:0]     lo_diff, hi_diff;
    logic                quiet, both, bad_code;

    // Range check via borrow bits keeps the compare valid for CP_MIN = 0.
    assign lo_diff  = {1'b0, cp_code[i*CODE_W +: CODE_W]} - MIN_V;
    assign hi_diff  = MAX_V - {1'b0, cp_code[i*CODE_W +: CODE_W]};
    assign bad_code = lo_diff[CODE_W] | hi_diff[CODE_W];
    assign quiet    = ~up[i] & ~down[i];
    assign both     = up[i] & down[i];
    assign s_base   = clr ? '0 : s;

    always_comb begin
      st_n = st;
      q_n  = q;
      a_n  = a;
      o_n  = o;
      e_n  = clr ? 3'b000 : e;
      s_n  = s_base;
      if (!en) begin
        st_n = IDLE;
        q_n  = '0;
        a_n  = '0;
        o_n  = '0;
      end else begin
        case (st)
          IDLE: st_n = ACQ;
          ACQ: begin
            if (!quiet) begin
              q_n = '0;
            end else if (q == QW'(LOCK_CYCLES - 1)) begin
              q_n  = '0;
              st_n = LOCKED;
            end else begin
              q_n = q + QW'(1);
            end
          end
          LOCKED: begin
            if (quiet) begin
              a_n = '0;
            end else if (a == AW'(SLIP_MAX - 1)) begin
              a_n  = '0;
              q_n  = '0;
              st_n = ACQ;
              if (s_base != S_SAT) s_n = s_base + SLIP_W'(1);
            end else begin
              a_n = a + AW'(1);
            end
          end
          default: st_n = IDLE;
        endcase
        // Error checks only run once the channel has left IDLE.
        if (st != IDLE) begin
          if (!d[i])   e_n[0] = 1'b1;
          if (bad_code) e_n[1] = 1'b1;
          if (both) begin
            o_n = (o == O_SAT) ? o : o + OW'(1);
            if (o_n == O_SAT) e_n[2] = 1'b1;
          end else begin
            o_n = '0;
          end
        end
      end
      lk_n = (st_n == LOCKED);
    end

    always_ff @(posedge refclk) begin
      if (!rst_n) begin
        st <= IDLE;
        q  <= '0;
        a  <= '0;
        o  <= '0;
        e  <= '0;
        s  <= '0;
        lk <= 1'b0;
      end else begin
        st <= st_n;
        q  <= q_n;
        a  <= a_n;
        o  <= o_n;
        e  <= e_n;
        s  <= s_n;
        lk <= lk_n;
      end
    end

    assign lock[i]                   = lk;
    assign err[3*i +: 3]             = e;
    assign slip_cnt[i*SLIP_W +: SLIP_W] = s;
  end

  always_ff @(posedge refclk) begin
    if (!rst_n) err_any <= 1'b0;
    else        err_any <= |err;
  end

`ifndef SYNTHESIS
  always @(posedge refclk) begin
    if (rst_n === 1'b1 && en !== 1'b0) begin
      for (int i = 0; i < int'(NCH); i++) begin
        if ($isunknown({en, d[i], up[i], down[i], cp_code[i*CODE_W +: CODE_W]}))
          $error("dms_pfd_lock_monitor: X/Z on inputs of channel %0d", i);
      end
    end
  end
`endif

endmodule

// File: tb/tb_dms_pfd_lock_monitor.sv
// Scoreboard bench for dms_pfd_lock_monitor: stimulus queues masked expected
// output snapshots per edge, a negedge monitor pops and compares them.
module tb_dms_pfd_lock_monitor;

  logic        refclk = 1'b0;
  logic        rst_n, en, clr;
  logic [1:0]  d, up, down;
  logic [15:0] cp_code;
  logic [1:0]  lock;
  logic [5:0]  err;
  logic        err_any;
  logic [7:0]  slip_cnt;

  dms_pfd_lock_monitor dut (
    .refclk   (refclk),
    .rst_n    (rst_n),
    .en       (en),
    .clr      (clr),
    .d        (d),
    .up       (up),
    .down     (down),
    .cp_code  (cp_code),
    .lock     (lock),
    .err      (err),
    .err_any  (err_any),
    .slip_cnt (slip_cnt)
  );

  always #5 refclk = ~refclk;

  // Observed snapshot layout: [1:0] lock, [7:2] err, [15:8] slip_cnt, [16] err_any.
  localparam logic [16:0] M_ALL    = 17'h1FFFF;
  localparam logic [16:0] M_LOCK   = 17'h00003;
  localparam logic [16:0] M_ERR    = 17'h000FC;
  localparam logic [16:0] M_ERRANY = 17'h10000;

  typedef struct {
    int          cyc;
    string       name;
    logic [16:0] mask;
    logic [16:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  function automatic logic [16:0] b_lock(int ch);
    return 17'(1) << ch;
  endfunction
  function automatic logic [16:0] b_err(int bitn);
    return 17'(1) << (2 + bitn);
  endfunction
  function automatic logic [16:0] m_slip(int ch);
    return 17'(15) << (8 + 4 * ch);
  endfunction
  function automatic logic [16:0] v_slip(int ch, int v);
    return 17'(v) << (8 + 4 * ch);
  endfunction

  always @(posedge refclk) cyc <= cyc + 1;

  always @(negedge refclk) begin
    logic [16:0] obs;
    exp_t        e;
    obs = {err_any, slip_cnt, err, lock};
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_chk++;
      if (e.cyc != cyc || ((obs ^ e.val) & e.mask) != 17'h0) begin
        n_fail++;
        $display("FAIL %s: cycle %0d got %05h want %05h mask %05h",
                 e.name, cyc, obs & e.mask, e.val, e.mask);
      end
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge refclk);
      #1;
    end
  endtask

  task automatic expect_now(string name, logic [16:0] mask, logic [16:0] val);
    exp_t e;
    e.cyc  = cyc;
    e.name = name;
    e.mask = mask;
    e.val  = val;
    sb.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; clr = 1'b0;
    d = 2'b11; up = 2'b00; down = 2'b00;
    cp_code = {8'd100, 8'd100};
    tick(2);
    expect_now("reset_state", M_ALL, 17'h0);

    // 1: acquisition from reset
    rst_n = 1'b1; en = 1'b1;
    tick(1);
    tick(15);
    expect_now("acq_no_lock_15", M_ALL, 17'h0);
    tick(1);
    expect_now("lock_at_16", M_ALL, 17'h00003);

    // 2: slip on ch0 and relock
    up = 2'b01;
    tick(3);
    expect_now("still_locked_3_active", M_LOCK, 17'h00003);
    tick(1);
    expect_now("slip_4th_active", M_LOCK | m_slip(0) | m_slip(1), b_lock(1) | v_slip(0, 1));
    up = 2'b00;
    tick(15);
    expect_now("relock_pending", M_LOCK, b_lock(1));
    tick(1);
    expect_now("relock_done", M_LOCK | m_slip(0), 17'h00003 | v_slip(0, 1));

    // 3: overlap tolerance and error
    up = 2'b01; down = 2'b01;
    tick(2);
    up = 2'b00; down = 2'b00;
    tick(1);
    expect_now("overlap_2_ok", M_ERR | M_ERRANY | M_LOCK, 17'h00003);
    up = 2'b01; down = 2'b01;
    tick(2);
    expect_now("overlap_2_again_ok", M_ERR, 17'h0);
    tick(1);
    expect_now("overlap_3_err", M_ERR | M_ERRANY, b_err(2));
    up = 2'b00; down = 2'b00;
    tick(1);
    expect_now("err_any_lag", M_ERR | M_ERRANY | M_LOCK | m_slip(0),
               b_err(2) | M_ERRANY | 17'h00003 | v_slip(0, 1));

    // 4: cp range on ch1
    cp_code = {8'd231, 8'd100};
    tick(1);
    expect_now("cp_231_err", M_ERR, b_err(2) | b_err(4));
    cp_code = {8'd100, 8'd100};
    tick(1);
    expect_now("cp_sticky", M_ERR, b_err(2) | b_err(4));
    clr = 1'b1;
    tick(1);
    expect_now("clr_clears", M_ERR | m_slip(0) | m_slip(1) | M_LOCK, 17'h00003);
    clr = 1'b0;
    cp_code = {8'd100, 8'd230};
    tick(1);
    expect_now("cp_230_ok", M_ERR | M_ERRANY, 17'h0);
    cp_code = {8'd100, 8'd0};
    tick(1);
    expect_now("cp_0_ok", M_ERR | M_ERRANY, 17'h0);
    cp_code = {8'd100, 8'd100};

    // 5: d low checks
    en = 1'b0;
    tick(2);
    expect_now("en_off_idle", M_LOCK | M_ERR, 17'h0);
    en = 1'b1; d = 2'b10;
    tick(1);
    expect_now("d_low_idle_ok", M_ERR | b_lock(0), 17'h0);
    tick(1);
    expect_now("d_low_acq_err", M_ERR, b_err(0));
    clr = 1'b1;
    tick(1);
    expect_now("clr_vs_d_low", M_ERR, b_err(0));
    clr = 1'b0; d = 2'b11;

    // 6: slip saturation then reset while locked
    en = 1'b0;
    tick(1);
    en = 1'b1;
    tick(1);
    for (int k = 1; k <= 17; k++) begin
      tick(16);
      expect_now($sformatf("sat_lock_%0d", k), b_lock(0), b_lock(0));
      up = 2'b01;
      tick(4);
      up = 2'b00;
      expect_now($sformatf("sat_slip_%0d", k), b_lock(0) | m_slip(0),
                 v_slip(0, (k > 15) ? 15 : k));
    end
    tick(16);
    expect_now("locked_before_rst", M_LOCK | M_ERR | M_ERRANY | m_slip(0),
               17'h00003 | b_err(0) | M_ERRANY | v_slip(0, 15));
    rst_n = 1'b0; clr = 1'b1;
    tick(1);
    expect_now("reset_mid_run", M_ALL, 17'h0);
    rst_n = 1'b1; clr = 1'b0;
    tick(16);
    expect_now("post_rst_acq", M_ALL, 17'h0);
    tick(1);
    expect_now("post_rst_lock", M_ALL, 17'h00003);

    tick(2);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
